// File: rtl/jericalla_control.sv
// Sequencer for the jericalla datapath: fetches 32-bit instructions, decodes
// register/ALU fields and issues one registered strobe per executed instruction.
//
// Handshake: instr is sampled only in FETCH on a cycle where instr_valid=1;
// there is no ready output, FETCH simply waits with pc held until valid arrives.
module jericalla_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic [4:0]  pc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  alu_sel,
    output logic        we,
    output logic        mem_we,
    output logic        buf_we,
    output logic        demux_en,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ir       <= 32'd0;
            pc       <= 5'd0;
            rs1      <= 5'd0;
            rs2      <= 5'd0;
            rd       <= 5'd0;
            alu_sel  <= 3'd0;
            we       <= 1'b0;
            mem_we   <= 1'b0;
            buf_we   <= 1'b0;
            demux_en <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            // Pulses default low so each is high for exactly the one cycle it was set for
            we       <= 1'b0;
            mem_we   <= 1'b0;
            buf_we   <= 1'b0;
            demux_en <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= 5'd0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rd      <= ir[25:21];
                    rs1     <= ir[20:16];
                    rs2     <= ir[15:11];
                    alu_sel <= ir[28:26];
                    // Strobes are set here so they are high during the EXEC cycle itself
                    case (ir[31:29])
                        3'b000: state <= S_EXEC;
                        3'b001: begin we       <= 1'b1; state <= S_EXEC; end
                        3'b010: begin mem_we   <= 1'b1; state <= S_EXEC; end
                        3'b011: begin buf_we   <= 1'b1; state <= S_EXEC; end
                        3'b100: begin demux_en <= 1'b1; state <= S_EXEC; end
                        3'b111: begin done     <= 1'b1; state <= S_DONE; end
                        default: begin illegal <= 1'b1; state <= S_IDLE; end
                    endcase
                end
                S_EXEC: begin
                    pc    <= pc + 5'd1;
                    state <= S_FETCH;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule
